// File: rtl/io_buttons_pkg.sv
// Shared constants, bus-lane helpers and request types for the io_buttons
// button/LED peripheral at fc40-fc4f.
package io_buttons_pkg;

    localparam logic [2:0]  REG_STATE    = 3'd0;
    localparam logic [2:0]  REG_PRESS    = 3'd1;
    localparam logic [2:0]  REG_RELEASE  = 3'd2;
    localparam logic [2:0]  REG_IRQEN    = 3'd3;
    localparam logic [2:0]  REG_LED      = 3'd4;
    localparam logic [2:0]  REG_DEBOUNCE = 3'd5;

    localparam logic [15:0] BASE_ADDR    = 16'hfc40;
    localparam logic [15:0] DB_DEFAULT   = 16'd25000;

    typedef enum logic [1:0] {
        LANE_WORD = 2'd0,
        LANE_LO   = 2'd1,
        LANE_HI   = 2'd2
    } lane_e;

    typedef struct packed {
        logic        we;
        logic [2:0]  idx;
        logic [15:0] data;
        logic [15:0] mask;
    } wreq_t;

    function automatic lane_e lane_sel(input logic wide, input logic a0);
        if (wide) begin
            return LANE_WORD;
        end else if (a0) begin
            return LANE_HI;
        end else begin
            return LANE_LO;
        end
    endfunction

    function automatic logic [15:0] lane_mask(input lane_e lane);
        case (lane)
            LANE_WORD: return 16'hffff;
            LANE_LO:   return 16'h00ff;
            LANE_HI:   return 16'hff00;
            default:   return 16'h0000;
        endcase
    endfunction

    // Byte writes always arrive on din[7:0]; steer them to the addressed lane.
    function automatic logic [15:0] lane_data(input lane_e lane, input logic [15:0] din);
        case (lane)
            LANE_WORD: return din;
            LANE_LO:   return {8'h00, din[7:0]};
            LANE_HI:   return {din[7:0], 8'h00};
            default:   return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] lane_merge(input logic [15:0] old_v,
                                               input logic [15:0] data,
                                               input logic [15:0] mask);
        return (old_v & ~mask) | (data & mask);
    endfunction

    // High-byte reads are returned right-justified on dout[7:0].
    function automatic logic [15:0] lane_read(input lane_e lane, input logic [15:0] r);
        case (lane)
            LANE_WORD: return r;
            LANE_LO:   return {8'h00, r[7:0]};
            LANE_HI:   return {8'h00, r[15:8]};
            default:   return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/io_buttons_if.sv
// CPU I/O bus as seen by the button/LED peripheral: same signalling as memory.
interface io_buttons_if;
    logic        en;
    logic        wr;
    logic        wide;
    logic [3:0]  addr;
    logic [15:0] din;
    logic [15:0] dout;

    modport master (output en, output wr, output wide, output addr, output din, input dout);
    modport slave  (input en, input wr, input wide, input addr, input din, output dout);
endinterface

// File: rtl/io_buttons_button_debounce.sv
// One button: 2-flop synchroniser, tick-sampled history and debounced level
// with registered rise/fall pulses.
module button_debounce #(
    parameter int SAMPLES = 4
) (
    input  logic clk,
    input  logic nreset,
    input  logic tick,
    input  logic btn,
    output logic level,
    output logic rise,
    output logic fall
);

    logic                sync1_r;
    logic                sync2_r;
    logic [SAMPLES-1:0]  hist_r;
    logic [SAMPLES-1:0]  hist_next_s;
    logic                state_r;
    logic                rise_r;
    logic                fall_r;

    // Two-stage synchroniser for the asynchronous button input
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

    // History shifts only on prescaler ticks
    always_comb begin
        hist_next_s = hist_r;
        if (tick) begin
            hist_next_s = {hist_r[SAMPLES-2:0], sync2_r};
        end else begin
            hist_next_s = hist_r;
        end
    end

    // Level changes only on a unanimous history; a mixed history holds it
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            hist_r  <= '0;
            state_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            hist_r <= hist_next_s;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            if (tick && (&hist_next_s) && !state_r) begin
                state_r <= 1'b1;
                rise_r  <= 1'b1;
            end else if (tick && !(|hist_next_s) && state_r) begin
                state_r <= 1'b0;
                fall_r  <= 1'b1;
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign level = state_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/io_buttons.sv
// Button/LED peripheral: debounced buttons with sticky press/release events
// and a maskable level interrupt, plus the board LED register.
module io_buttons #(
    parameter int          NBTN       = 7,
    parameter int          SAMPLES    = 4,
    parameter logic [15:0] DB_DEFAULT = io_buttons_pkg::DB_DEFAULT
) (
    input  logic             clk,
    input  logic             nreset,
    io_buttons_if.slave      bus,
    input  logic [NBTN-1:0]  btn,
    output logic [7:0]       led,
    output logic             irq
);
    import io_buttons_pkg::*;

    localparam logic [15:0] BTN_MASK = 16'((32'd1 << NBTN) - 32'd1);

    lane_e           lane_s;
    wreq_t           wreq_s;
    logic            tick_s;
    logic            deb_wr_s;
    logic [15:0]     cnt_r;
    logic [15:0]     debounce_r;
    logic [15:0]     press_r;
    logic [15:0]     release_r;
    logic [15:0]     irq_en_r;
    logic [7:0]      led_r;
    logic            irq_r;
    logic [15:0]     dout_r;
    logic [15:0]     rdata_s;
    logic [15:0]     press_clr_s;
    logic [15:0]     release_clr_s;
    logic [15:0]     irq_en_next_s;
    logic [15:0]     debounce_next_s;
    logic [7:0]      led_next_s;
    logic [NBTN-1:0] state_s;
    logic [NBTN-1:0] rise_s;
    logic [NBTN-1:0] fall_s;
    logic [15:0]     state_vec_s;
    logic [15:0]     rise_vec_s;
    logic [15:0]     fall_vec_s;

    assign state_vec_s = 16'(state_s);
    assign rise_vec_s  = 16'(rise_s);
    assign fall_vec_s  = 16'(fall_s);

    // Decode the bus cycle into a lane-aligned write request
    always_comb begin
        lane_s      = lane_sel(bus.wide, bus.addr[0]);
        wreq_s.we   = bus.en & bus.wr;
        wreq_s.idx  = bus.addr[3:1];
        wreq_s.data = lane_data(lane_s, bus.din);
        wreq_s.mask = lane_mask(lane_s);
    end

    // Next values for software-writable registers
    always_comb begin
        deb_wr_s        = wreq_s.we && (wreq_s.idx == REG_DEBOUNCE);
        press_clr_s     = 16'h0000;
        release_clr_s   = 16'h0000;
        irq_en_next_s   = irq_en_r;
        led_next_s      = led_r;
        debounce_next_s = debounce_r;
        if (wreq_s.we) begin
            case (wreq_s.idx)
                REG_PRESS:    press_clr_s     = wreq_s.data & wreq_s.mask;
                REG_RELEASE:  release_clr_s   = wreq_s.data & wreq_s.mask;
                REG_IRQEN:    irq_en_next_s   = lane_merge(irq_en_r, wreq_s.data, wreq_s.mask) & BTN_MASK;
                // LED only has a low lane; high-lane writes fall away
                REG_LED:      led_next_s      = wreq_s.mask[0] ? wreq_s.data[7:0] : led_r;
                REG_DEBOUNCE: debounce_next_s = lane_merge(debounce_r, wreq_s.data, wreq_s.mask);
                default:      press_clr_s     = 16'h0000;
            endcase
        end else begin
            press_clr_s = 16'h0000;
        end
    end

    // Read-data mux; unused words read zero
    always_comb begin
        rdata_s = 16'h0000;
        case (bus.addr[3:1])
            REG_STATE:    rdata_s = state_vec_s;
            REG_PRESS:    rdata_s = press_r;
            REG_RELEASE:  rdata_s = release_r;
            REG_IRQEN:    rdata_s = irq_en_r;
            REG_LED:      rdata_s = {8'h00, led_r};
            REG_DEBOUNCE: rdata_s = debounce_r;
            default:      rdata_s = 16'h0000;
        endcase
    end

    assign tick_s = (cnt_r == debounce_r);

    // Sample prescaler; a DEBOUNCE write restarts the period
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_r <= 16'h0000;
        end else if (deb_wr_s || tick_s) begin
            cnt_r <= 16'h0000;
        end else begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        button_debounce #(.SAMPLES(SAMPLES)) u_db (
            .clk    (clk),
            .nreset (nreset),
            .tick   (tick_s),
            .btn    (btn[i]),
            .level  (state_s[i]),
            .rise   (rise_s[i]),
            .fall   (fall_s[i])
        );
    end

    // Register file, interrupt and read data; a hardware event beats a W1C
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            press_r    <= 16'h0000;
            release_r  <= 16'h0000;
            irq_en_r   <= 16'h0000;
            led_r      <= 8'h00;
            debounce_r <= DB_DEFAULT;
            irq_r      <= 1'b0;
            dout_r     <= 16'h0000;
        end else begin
            press_r    <= ((press_r & ~press_clr_s) | rise_vec_s) & BTN_MASK;
            release_r  <= ((release_r & ~release_clr_s) | fall_vec_s) & BTN_MASK;
            irq_en_r   <= irq_en_next_s;
            led_r      <= led_next_s;
            debounce_r <= debounce_next_s;
            irq_r      <= |(press_r & irq_en_r);
            if (bus.en && !bus.wr) begin
                dout_r <= lane_read(lane_s, rdata_s);
            end else begin
                dout_r <= dout_r;
            end
        end
    end

    assign bus.dout = dout_r;
    assign led      = led_r;
    assign irq      = irq_r;

endmodule

// File: tb/tb_io_buttons.sv
// Randomised bench for io_buttons with an event-level reference model and a
// few directed scenarios pinned to literal values.
module tb_io_buttons;
    localparam int NB = 7;
    localparam int S  = 4;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic [NB-1:0] btn;
    logic [7:0]    led;
    logic          irq;
    logic [15:0]   q;

    io_buttons_if bus();

    io_buttons #(.NBTN(NB), .SAMPLES(S), .DB_DEFAULT(16'd25000)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus),
        .btn    (btn),
        .led    (led),
        .irq    (irq)
    );

    always #20 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic          m_valid = 1'b0;
    logic [NB-1:0] m_s1, m_s2, m_state, m_press, m_rel, m_irqen, m_rise, m_fall;
    logic [15:0]   m_deb, m_cnt, m_dout;
    logic [7:0]    m_led;
    logic          m_irq;
    logic          m_last [NB];
    int            m_run  [NB];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_state = '0; m_press = '0; m_rel = '0;
        m_irqen = '0; m_rise = '0; m_fall = '0;
        m_deb = 16'd25000; m_cnt = 16'd0; m_dout = 16'd0; m_led = 8'd0; m_irq = 1'b0;
        for (int i = 0; i < NB; i++) begin
            m_last[i] = 1'b0;
            m_run[i]  = S;
        end
    endtask

    function automatic logic [15:0] m_reg(input int idx);
        case (idx)
            0: return 16'(m_state);
            1: return 16'(m_press);
            2: return 16'(m_rel);
            3: return 16'(m_irqen);
            4: return {8'h00, m_led};
            5: return m_deb;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] m_lane(input logic [15:0] old_v);
        if (bus.wide) return bus.din;
        else if (bus.addr[0]) return {bus.din[7:0], old_v[7:0]};
        else return {old_v[15:8], bus.din[7:0]};
    endfunction

    task automatic model_step();
        logic          tick, wr_on, smp;
        int            idx;
        logic [15:0]   val, wv, tmp;
        logic [NB-1:0] clrp, clrr, nrise, nfall, np, nr;
        logic          nirq;
        tick  = (m_cnt == m_deb);
        idx   = int'(bus.addr[3:1]);
        wr_on = bus.en && bus.wr;
        if (bus.en && !bus.wr) begin
            val = m_reg(idx);
            m_dout = bus.wide ? val : (bus.addr[0] ? {8'h00, val[15:8]} : {8'h00, val[7:0]});
        end
        wv = bus.wide ? bus.din : (bus.addr[0] ? {bus.din[7:0], 8'h00} : {8'h00, bus.din[7:0]});
        clrp = (wr_on && idx == 1) ? wv[NB-1:0] : '0;
        clrr = (wr_on && idx == 2) ? wv[NB-1:0] : '0;
        np   = (m_press & ~clrp) | m_rise;
        nr   = (m_rel & ~clrr) | m_fall;
        nirq = |(m_press & m_irqen);
        nrise = '0;
        nfall = '0;
        if (tick) begin
            for (int i = 0; i < NB; i++) begin
                smp = m_s2[i];
                if (smp == m_last[i]) m_run[i] = (m_run[i] < S) ? m_run[i] + 1 : S;
                else begin m_last[i] = smp; m_run[i] = 1; end
                if (m_run[i] >= S && m_last[i] && !m_state[i]) begin
                    m_state[i] = 1'b1; nrise[i] = 1'b1;
                end else if (m_run[i] >= S && !m_last[i] && m_state[i]) begin
                    m_state[i] = 1'b0; nfall[i] = 1'b1;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = btn;
        m_cnt = (wr_on && idx == 5) ? 16'd0 : (tick ? 16'd0 : m_cnt + 16'd1);
        if (wr_on && idx == 3) begin tmp = m_lane(16'(m_irqen)); m_irqen = tmp[NB-1:0]; end
        if (wr_on && idx == 4 && (bus.wide || !bus.addr[0])) m_led = bus.din[7:0];
        if (wr_on && idx == 5) m_deb = m_lane(m_deb);
        m_press = np; m_rel = nr; m_irq = nirq;
        m_rise = nrise; m_fall = nfall;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge nreset);
            if (!nreset) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison of every DUT output against the model
    initial begin
        forever begin
            @(negedge clk);
            if (nreset && m_valid) begin
                chk("dout", bus.dout, m_dout);
                chk("led", {8'h00, led}, {8'h00, m_led});
                chk("irq", {15'h0000, irq}, {15'h0000, m_irq});
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bus tasks ----------------
    task automatic bus_wr(input logic [3:0] a, input logic w, input logic [15:0] d);
        @(negedge clk);
        bus.en = 1'b1; bus.wr = 1'b1; bus.wide = w; bus.addr = a; bus.din = d;
        @(negedge clk);
        bus.en = 1'b0; bus.wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, input logic w, output logic [15:0] d);
        @(negedge clk);
        bus.en = 1'b1; bus.wr = 1'b0; bus.wide = w; bus.addr = a; bus.din = 16'h0000;
        @(negedge clk);
        bus.en = 1'b0;
        d = bus.dout;
    endtask

    initial begin
        logic [3:0]  ra;
        logic        rw;
        logic [15:0] rd;
        int          k;
        bus.en = 1'b0; bus.wr = 1'b0; bus.wide = 1'b0; bus.addr = 4'h0; bus.din = 16'h0000;
        btn = '0;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        m_valid = 1'b1;

        chk("rst_led", {8'h00, led}, 16'h0000);
        chk("rst_irq", {15'h0000, irq}, 16'h0000);
        bus_rd(4'h0, 1'b1, q); chk("rst_state", q, 16'h0000);
        bus_rd(4'h2, 1'b1, q); chk("rst_press", q, 16'h0000);
        bus_rd(4'h6, 1'b1, q); chk("rst_irqen", q, 16'h0000);
        bus_rd(4'h8, 1'b1, q); chk("rst_ledreg", q, 16'h0000);
        bus_rd(4'ha, 1'b1, q); chk("rst_debounce", q, 16'h61a8);

        // Steady press on button 2
        bus_wr(4'ha, 1'b1, 16'h0003);
        btn[2] = 1'b1;
        repeat (8) @(negedge clk);
        bus_rd(4'h0, 1'b1, q); chk("state_early", q, 16'h0000);
        repeat (20) @(negedge clk);
        bus_rd(4'h0, 1'b1, q); chk("state_b2", q, 16'h0004);
        bus_rd(4'h2, 1'b1, q); chk("press_b2", q, 16'h0004);

        // One-tick glitch on button 5
        btn[5] = 1'b1;
        repeat (4) @(negedge clk);
        btn[5] = 1'b0;
        repeat (25) @(negedge clk);
        bus_rd(4'h0, 1'b1, q); chk("glitch_state", q, 16'h0004);
        bus_rd(4'h2, 1'b1, q); chk("glitch_press", q, 16'h0004);

        // Interrupt enable and write-1-to-clear
        bus_wr(4'h6, 1'b1, 16'h0004);
        repeat (2) @(negedge clk);
        chk("irq_on", {15'h0000, irq}, 16'h0001);
        bus_wr(4'h2, 1'b1, 16'h0000);
        bus_rd(4'h2, 1'b1, q); chk("w1c_zero", q, 16'h0004);
        bus_wr(4'h2, 1'b1, 16'h0004);
        chk("irq_lag", {15'h0000, irq}, 16'h0001);
        @(negedge clk);
        chk("irq_off", {15'h0000, irq}, 16'h0000);
        bus_rd(4'h2, 1'b1, q); chk("w1c_cleared", q, 16'h0000);

        // W1C coinciding with a new press event on button 1
        btn[1] = 1'b1;
        k = 0;
        while (k < 200 && !m_rise[1]) begin
            @(negedge clk);
            k++;
        end
        chk("race_wait", {15'h0000, m_rise[1]}, 16'h0001);
        bus.en = 1'b1; bus.wr = 1'b1; bus.wide = 1'b1; bus.addr = 4'h2; bus.din = 16'h0002;
        @(negedge clk);
        bus.en = 1'b0; bus.wr = 1'b0;
        bus_rd(4'h2, 1'b1, q); chk("race_press", q, 16'h0002);

        // Byte lanes
        bus_wr(4'h8, 1'b0, 16'h005a);
        chk("led_byte", {8'h00, led}, 16'h005a);
        bus_wr(4'hb, 1'b0, 16'h0012);
        bus_rd(4'hb, 1'b0, q); chk("deb_hi_byte", q, 16'h0012);
        bus_rd(4'ha, 1'b1, q); chk("deb_word", q, 16'h1203);
        bus_wr(4'ha, 1'b1, 16'h0003);

        // Read latency, hold, and unimplemented words
        bus_rd(4'h0, 1'b1, q); chk("state_read", q, 16'h0006);
        repeat (3) @(negedge clk);
        chk("dout_hold", bus.dout, 16'h0006);
        bus_rd(4'hc, 1'b1, q); chk("rd_0c", q, 16'h0000);
        bus_rd(4'he, 1'b1, q); chk("rd_0e", q, 16'h0000);

        // Randomised traffic and button noise
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) btn = NB'($urandom);
            ra = 4'($urandom_range(0, 15));
            rw = 1'($urandom_range(0, 1));
            rd = 16'($urandom);
            if (ra[3:1] == 3'd5) begin
                rw = 1'b1;
                rd = 16'($urandom_range(0, 4));
            end
            if ($urandom_range(0, 1) == 1) bus_wr(ra, rw, rd);
            else bus_rd(ra, rw, q);
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end

        // Asynchronous reset mid-cycle with button 3 held through it
        btn = 7'b0001000;
        bus_wr(4'h8, 1'b1, 16'h00a5);
        @(posedge clk);
        #7 nreset = 1'b0;
        #1;
        chk("async_led", {8'h00, led}, 16'h0000);
        chk("async_irq", {15'h0000, irq}, 16'h0000);
        chk("async_dout", bus.dout, 16'h0000);
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        bus_wr(4'ha, 1'b1, 16'h0001);
        repeat (40) @(negedge clk);
        bus_rd(4'h0, 1'b1, q); chk("held_state", q, 16'h0008);
        bus_rd(4'h2, 1'b1, q); chk("held_press", q, 16'h0008);
        bus_rd(4'h4, 1'b1, q); chk("held_release", q, 16'h0000);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
